// File: rtl/fb_rect_filler.sv
// Rectangle-fill / clear-screen drawing engine feeding the framebuffer write port.
// Optional FB_RECT_CLIP_EN: clamp far corners to the screen instead of rejecting.
module fb_rect_filler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              iclk,
    input  logic              iRST_n,
    input  logic              icmd_valid,
    output logic              ocmd_ready,
    input  logic              icmd_clear,
    input  logic [9:0]        ix0,
    input  logic [8:0]        iy0,
    input  logic [9:0]        ix1,
    input  logic [8:0]        iy1,
    input  logic [7:0]        icolor,
    output logic              owren,
    output logic [ADDR_W-1:0] oaddr,
    output logic [7:0]        odata,
    output logic              obusy,
    output logic              odone,
    output logic              oerr
);

    localparam logic [9:0]        H_MAX  = 10'(H_ACTIVE - 1);
    localparam logic [8:0]        V_MAX  = 9'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [2:0] {IDLE, SETUP, FILL, DONE, REJECT} state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic [9:0]        xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
    logic [8:0]        ymin_q, ymin_d, ymax_q, ymax_d, y_q, y_d;
    logic [ADDR_W-1:0] rowbase_q, rowbase_d;
    logic [7:0]        color_q, color_d;
    logic              owren_q, owren_d, odone_q, odone_d, oerr_q, oerr_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [7:0]        odata_q, odata_d;

    logic              accept;
    logic              range_bad;
    logic [9:0]        nx_min, nx_max;
    logic [8:0]        ny_min, ny_max;
    logic [ADDR_W-1:0] row_acc;

    // Handshake: a command transfers on a posedge where icmd_valid and ocmd_ready are
    // both high; ready drops for the whole command and is not re-raised on the first IDLE cycle.
    assign accept     = icmd_valid & ready_q;
    assign ocmd_ready = ready_q;
    assign obusy      = (state_q != IDLE);
    assign owren      = owren_q;
    assign oaddr      = oaddr_q;
    assign odata      = odata_q;
    assign odone      = odone_q;
    assign oerr       = oerr_q;

    always_ff @(posedge iclk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            rowbase_q <= '0;
            color_q   <= '0;
            owren_q   <= 1'b0;
            oaddr_q   <= '0;
            odata_q   <= '0;
            odone_q   <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rowbase_q <= rowbase_d;
            color_q   <= color_d;
            owren_q   <= owren_d;
            oaddr_q   <= oaddr_d;
            odata_q   <= odata_d;
            odone_q   <= odone_d;
            oerr_q    <= oerr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = (state_q == IDLE) && !accept;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        x_d       = x_q;
        y_d       = y_q;
        rowbase_d = rowbase_q;
        color_d   = color_q;

        nx_min = (ix0 < ix1) ? ix0 : ix1;
        nx_max = (ix0 < ix1) ? ix1 : ix0;
        ny_min = (iy0 < iy1) ? iy0 : iy1;
        ny_max = (iy0 < iy1) ? iy1 : iy0;
        if (icmd_clear) begin
            nx_min = '0;
            nx_max = H_MAX;
            ny_min = '0;
            ny_max = V_MAX;
        end
`ifdef FB_RECT_CLIP_EN
        range_bad = (nx_min > H_MAX) || (ny_min > V_MAX);
        if (nx_max > H_MAX) nx_max = H_MAX;
        if (ny_max > V_MAX) ny_max = V_MAX;
`else
        range_bad = (nx_max > H_MAX) || (ny_max > V_MAX);
`endif

        // Constant multiply ymin*H_ACTIVE as a sum of shifted copies.
        row_acc = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (H_STEP[i]) row_acc = row_acc + (ADDR_W'(ymin_q) << i);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    xmin_d  = nx_min;
                    xmax_d  = nx_max;
                    ymin_d  = ny_min;
                    ymax_d  = ny_max;
                    color_d = icolor;
                    state_d = range_bad ? REJECT : SETUP;
                end
            end
            SETUP: begin
                rowbase_d = row_acc;
                x_d       = xmin_q;
                y_d       = ymin_q;
                state_d   = FILL;
            end
            FILL: begin
                if (x_q == xmax_q) begin
                    x_d       = xmin_q;
                    y_d       = y_q + 9'd1;
                    rowbase_d = rowbase_q + H_STEP;
                    if (y_q == ymax_q) state_d = DONE;
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
            DONE:    state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owren_d = (state_q == FILL);
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        if (state_q == FILL) begin
            oaddr_d = rowbase_q + ADDR_W'(x_q);
            odata_d = color_q;
        end
        odone_d = (state_q == DONE);
        oerr_d  = (state_q == REJECT);
    end

endmodule
